// File: rtl/xoodyak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xoodyak_pkg
//  Description : Shared definitions for the XOODOO core arbiter slice:
//                permutation state width, requester count and the
//                arbiter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package xoodyak_pkg;

    // Width of the XOODOO permutation state (12 lanes x 32 bits).
    localparam int STATE_W = 384;

    // Number of sponge front-ends sharing one permutation core.
    localparam int c_num_req = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage : xoodyak_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way round-robin picker. When both
//                requesters are eligible the pointer decides; otherwise the
//                single eligible requester wins.
//  Ports       : eligible[1:0] in  - requesters allowed to win this cycle
//                rr_ptr        in  - preferred requester on a tie
//                pick          out - index of the winner (valid when any=1)
//                any           out - at least one requester is eligible
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import xoodyak_pkg::*;
(
    input  logic [c_num_req-1:0] eligible,
    input  logic                 rr_ptr,
    output logic                 pick,
    output logic                 any
);

    always_comb begin
        any  = |eligible;
        pick = 1'b0;
        if (&eligible) begin
            pick = rr_ptr;
        end else begin
            // Only bit 1 set -> 1; only bit 0 set (or none) -> 0.
            pick = eligible[1];
        end
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/xoodoo_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : xoodoo_core_arbiter
//  Description : Shares one XOODOO permutation core between two XOODYAK
//                sponge front-ends. Grants round-robin, snapshots the
//                granted state, runs the core enable/done handshake, returns
//                the result with a one-cycle done pulse, and aborts a run
//                that exceeds TIMEOUT busy cycles.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                req_valid[1:0]      - per-requester request (held to done)
//                req_state0/1        - requester states
//                done[1:0], err      - completion pulse, watchdog abort flag
//                state_out           - permuted state, held until next capture
//                grant_id, busy      - last served requester, FSM not idle
//                core_enable         - XOODOO enable
//                core_state_in       - registered snapshot fed to the core
//                core_state_out      - core result
//                core_done           - core completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module xoodoo_core_arbiter
    import xoodyak_pkg::arb_state_t, xoodyak_pkg::IDLE, xoodyak_pkg::BUSY,
           xoodyak_pkg::DONE, xoodyak_pkg::c_num_req;
#(
    parameter int STATE_W = 384,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [c_num_req-1:0] req_valid,
    input  logic [STATE_W-1:0]   req_state0,
    input  logic [STATE_W-1:0]   req_state1,
    output logic [c_num_req-1:0] done,
    output logic                 err,
    output logic [STATE_W-1:0]   state_out,
    output logic                 grant_id,
    output logic                 busy,
    output logic                 core_enable,
    output logic [STATE_W-1:0]   core_state_in,
    input  logic [STATE_W-1:0]   core_state_out,
    input  logic                 core_done
);

    // Watchdog count reached on the last BUSY cycle a run is allowed.
    localparam logic [CNT_W-1:0] c_wd_last = CNT_W'(TIMEOUT - 1);

    arb_state_t                 r_state;
    arb_state_t                 w_state_nxt;
    logic                       r_grant_id,      w_grant_nxt;
    logic                       r_rr_ptr,        w_rr_nxt;
    logic [c_num_req-1:0]       r_mask,          w_mask_nxt;
    logic [CNT_W-1:0]           r_wd_cnt,        w_wd_nxt;
    logic [STATE_W-1:0]         r_core_state_in, w_csi_nxt;
    logic [STATE_W-1:0]         r_state_out,     w_sout_nxt;
    logic                       r_core_enable,   w_en_nxt;
    logic                       r_err,           w_err_nxt;

    logic [c_num_req-1:0]       w_eligible;
    logic                       w_pick;
    logic                       w_any;
    logic [c_num_req-1:0]       w_grant_onehot;

    // The mask is only non-zero in the first IDLE cycle after DONE, so a
    // requester that drops req_valid one cycle late is not served twice.
    assign w_eligible     = req_valid & ~r_mask;
    assign w_grant_onehot = {r_grant_id, ~r_grant_id};

    rr_pick2 u_pick (
        .eligible (w_eligible),
        .rr_ptr   (r_rr_ptr),
        .pick     (w_pick),
        .any      (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_rr_nxt    = r_rr_ptr;
        w_mask_nxt  = r_mask;
        w_wd_nxt    = r_wd_cnt;
        w_csi_nxt   = r_core_state_in;
        w_sout_nxt  = r_state_out;
        w_en_nxt    = r_core_enable;
        w_err_nxt   = r_err;

        case (r_state)
            IDLE: begin
                w_mask_nxt = '0;
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_csi_nxt   = w_pick ? req_state1 : req_state0;
                    w_en_nxt    = 1'b1;
                    w_wd_nxt    = '0;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_wd_nxt = r_wd_cnt + CNT_W'(1);
                // A real completion wins over an abort on the same cycle.
                if (core_done) begin
                    w_sout_nxt  = core_state_out;
                    w_en_nxt    = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = DONE;
                end else if (r_wd_cnt == c_wd_last) begin
                    w_en_nxt    = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Pointer flips after every service, aborted ones included.
                w_rr_nxt    = ~r_grant_id;
                w_mask_nxt  = w_grant_onehot;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_grant_id      <= 1'b0;
            r_rr_ptr        <= 1'b0;
            r_mask          <= '0;
            r_wd_cnt        <= '0;
            r_core_state_in <= '0;
            r_state_out     <= '0;
            r_core_enable   <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_grant_id      <= w_grant_nxt;
            r_rr_ptr        <= w_rr_nxt;
            r_mask          <= w_mask_nxt;
            r_wd_cnt        <= w_wd_nxt;
            r_core_state_in <= w_csi_nxt;
            r_state_out     <= w_sout_nxt;
            r_core_enable   <= w_en_nxt;
            r_err           <= w_err_nxt;
        end
    end

    assign done          = (r_state == DONE) ? w_grant_onehot : '0;
    assign err           = (r_state == DONE) & r_err;
    assign busy          = (r_state != IDLE);
    assign grant_id      = r_grant_id;
    assign core_enable   = r_core_enable;
    assign core_state_in = r_core_state_in;
    assign state_out     = r_state_out;

endmodule : xoodoo_core_arbiter
`default_nettype wire

// File: tb/tb_xoodoo_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xoodoo_core_arbiter
//  Description : Self-checking bench for xoodoo_core_arbiter: a per-cycle
//                vector table, directed multi-cycle sequences and a
//                randomized run against a transaction-level timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xoodoo_core_arbiter;
    import xoodyak_pkg::*;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;
    localparam int NEVER   = -1;
    localparam logic [STATE_W-1:0] GARB = {(STATE_W/32){32'hDEADBEEF}};

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [STATE_W-1:0] req_state0, req_state1;
    logic [1:0]         done;
    logic               err;
    logic [STATE_W-1:0] state_out;
    logic               grant_id, busy, core_enable;
    logic [STATE_W-1:0] core_state_in, core_state_out;
    logic               core_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xoodoo_core_arbiter #(
        .STATE_W (STATE_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_state0     (req_state0),
        .req_state1     (req_state1),
        .done           (done),
        .err            (err),
        .state_out      (state_out),
        .grant_id       (grant_id),
        .busy           (busy),
        .core_enable    (core_enable),
        .core_state_in  (core_state_in),
        .core_state_out (core_state_out),
        .core_done      (core_done)
    );

    typedef struct {
        logic [1:0] rv;
        logic       cd;
        logic [1:0] e_done;
        logic       e_err;
        logic       e_busy;
        logic       e_en;
        logic       e_gid;
        int         e_sel;   // 0: zero, 1: ~state A, 2: ~state B
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [STATE_W-1:0] act,
                       input logic [STATE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [STATE_W-1:0] rand_state();
        logic [STATE_W-1:0] r;
        for (int i = 0; i < STATE_W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        reset          = 1'b1;
        req_valid      = 2'b00;
        core_done      = 1'b0;
        core_state_out = GARB;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset(input string p);
        chk({p, ".busy"}, busy, 0);
        chk({p, ".en"},   core_enable, 0);
        chk({p, ".done"}, done, 0);
        chk({p, ".err"},  err, 0);
        chk({p, ".gid"},  grant_id, 0);
        chk({p, ".sout"}, state_out, 0);
        chk({p, ".csi"},  core_state_in, 0);
    endtask

    // Issue one request, act as a core with latency p (NEVER = no done) and
    // check the done cycle relative to the request cycle.
    task automatic run_req(input string name, input logic [1:0] rv, input int p,
                           input int exp_lat, input logic exp_err,
                           input logic [1:0] exp_done,
                           input logic [STATE_W-1:0] exp_sout, input bit late);
        int   rise;
        int   lat;
        logic prev_en;
        rise = -1; lat = -1; prev_en = 1'b0;
        req_valid = rv;
        for (int k = 0; k < 200; k++) begin
            if (core_enable && !prev_en) rise = k;
            prev_en = core_enable;
            core_done = (p >= 0) && (rise >= 0) && (k == rise + p);
            core_state_out = core_enable ? ~core_state_in : GARB;
            if (done != 2'b00) begin
                lat = k;
                break;
            end
            tick();
        end
        core_done = 1'b0;
        chk_int({name, ".latency"}, lat, exp_lat);
        chk({name, ".done"}, done, exp_done);
        chk({name, ".err"},  err, exp_err);
        chk({name, ".sout"}, state_out, exp_sout);
        chk({name, ".en_low_at_done"}, core_enable, 0);
        chk({name, ".gid"},  grant_id, exp_done[1]);
        if (!late) begin
            req_valid = 2'b00;
            tick();
            tick();
        end else begin
            tick();   // masked cycle, request still held
            chk({name, ".mask_busy"}, busy, 0);
            chk({name, ".mask_en"}, core_enable, 0);
            tick();   // mask gone, request still high -> grant here
            chk({name, ".idle_busy"}, busy, 0);
            tick();
            chk({name, ".regrant_en"}, core_enable, 1);
            chk({name, ".regrant_gid"}, grant_id, rv[1]);
            chk({name, ".regrant_csi"}, core_state_in, rv[1] ? req_state1 : req_state0);
            req_valid = 2'b00;
        end
    endtask

    // Randomized run checked against a timeline model: each grant fixes the
    // cycles at which enable rises, done pulses and the arbiter is free again.
    task automatic random_phase(input int cycles);
        bit                 m_active = 0;
        int                 m_g = 0, m_done_cyc = 0, m_p = 0, m_free = 0;
        logic               m_req = 0, m_err_run = 0, m_last = 0, m_pref = 0;
        bit                 m_have_last = 0;
        logic               m_gid = 0;
        logic [STATE_W-1:0] m_snap = '0, m_csi = '0, m_sout = '0;
        logic [1:0]         prev_done_exp = 2'b00, rq_v = 2'b00, rq_late = 2'b00;
        logic [1:0]         elig, e_done;
        logic               e_busy, e_en, e_err;
        bit                 c_active = 0;
        int                 c_rise = 0;
        logic               c_prev_en = 0;
        int                 sel;

        do_reset();
        for (int n = 0; n < cycles; n++) begin
            if (m_active && n == m_g + 1) begin
                m_gid = m_req;
                m_csi = m_snap;
            end
            if (m_active && n == m_done_cyc && !m_err_run) m_sout = ~m_snap;

            e_busy = m_active && (n > m_g);
            e_en   = m_active && (n > m_g) && (n < m_done_cyc);
            e_done = (m_active && n == m_done_cyc) ? (m_req ? 2'b10 : 2'b01) : 2'b00;
            e_err  = m_active && (n == m_done_cyc) && m_err_run;
            chk($sformatf("rnd.busy@%0d", n), busy, e_busy);
            chk($sformatf("rnd.en@%0d", n),   core_enable, e_en);
            chk($sformatf("rnd.done@%0d", n), done, e_done);
            chk($sformatf("rnd.err@%0d", n),  err, e_err);
            chk($sformatf("rnd.gid@%0d", n),  grant_id, m_gid);
            chk($sformatf("rnd.csi@%0d", n),  core_state_in, m_csi);
            chk($sformatf("rnd.sout@%0d", n), state_out, m_sout);

            // Core: answers ~input m_p cycles after enable rises; stray
            // done pulses while it is disabled.
            if (!core_enable) c_active = 0;
            if (core_enable && !c_prev_en) begin
                c_active = 1;
                c_rise   = n;
            end
            c_prev_en = core_enable;
            if (c_active && m_p >= 0 && n == c_rise + m_p) begin
                core_done      = 1'b1;
                core_state_out = ~core_state_in;
                c_active       = 0;
            end else begin
                core_done      = !core_enable && ($urandom_range(0, 7) == 0);
                core_state_out = rand_state();
            end

            // Requesters: drop after done (sometimes one cycle late), then
            // raise new requests at random with a fresh state.
            for (int r = 0; r < 2; r++) begin
                if (prev_done_exp[r]) begin
                    if ($urandom_range(0, 3) == 0) rq_late[r] = 1'b1;
                    else rq_v[r] = 1'b0;
                end else if (rq_late[r]) begin
                    rq_late[r] = 1'b0;
                    rq_v[r]    = 1'b0;
                end else if (!rq_v[r] && $urandom_range(0, 2) == 0) begin
                    rq_v[r] = 1'b1;
                    if (r == 0) req_state0 = rand_state();
                    else        req_state1 = rand_state();
                end
            end
            req_valid     = rq_v;
            prev_done_exp = e_done;

            if (m_active && n == m_done_cyc) begin
                m_active    = 0;
                m_free      = n + 1;
                m_have_last = 1;
                m_last      = m_req;
                m_pref      = ~m_req;
            end

            if (!m_active && n >= m_free) begin
                elig = rq_v & ~((n == m_free && m_have_last) ?
                                (m_last ? 2'b10 : 2'b01) : 2'b00);
                if (elig != 2'b00) begin
                    m_req    = (elig == 2'b11) ? m_pref : elig[1];
                    m_active = 1;
                    m_g      = n;
                    m_snap   = m_req ? req_state1 : req_state0;
                    sel      = $urandom_range(0, 9);
                    if (sel == 0)      m_p = NEVER;
                    else if (sel == 1) m_p = TIMEOUT - 1;
                    else if (sel == 2) m_p = TIMEOUT;
                    else               m_p = $urandom_range(0, 15);
                    m_err_run  = (m_p < 0) || (m_p > TIMEOUT - 1);
                    m_done_cyc = m_g + 2 + (m_err_run ? TIMEOUT - 1 : m_p);
                end
            end
            tick();
        end
        core_done = 1'b0;
        req_valid = 2'b00;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t               tv[15];
        logic [STATE_W-1:0] st_a, st_b, exp_s;

        reset = 1'b1; req_valid = 2'b00; core_done = 1'b0;
        req_state0 = '0; req_state1 = '0; core_state_out = GARB;

        // ---- table: contention, late drop with mask, stray core_done ----
        tv[0]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tv[1]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tv[2]  = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tv[3]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tv[4]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tv[5]  = '{2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1};
        tv[6]  = '{2'b10, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1};
        tv[7]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 2};
        tv[8]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tv[9]  = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tv[10] = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        tv[11] = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        tv[12] = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tv[13] = '{2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tv[14] = '{2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1};

        st_a = rand_state();
        st_b = rand_state();
        do_reset();
        check_reset("reset");
        req_state0 = st_a;
        req_state1 = st_b;
        for (int i = 0; i < 15; i++) begin
            req_valid      = tv[i].rv;
            core_done      = tv[i].cd;
            core_state_out = core_enable ? ~core_state_in : GARB;
            exp_s = (tv[i].e_sel == 0) ? '0 : (tv[i].e_sel == 1) ? ~st_a : ~st_b;
            chk($sformatf("tbl%0d.done", i), done, tv[i].e_done);
            chk($sformatf("tbl%0d.err", i),  err, tv[i].e_err);
            chk($sformatf("tbl%0d.busy", i), busy, tv[i].e_busy);
            chk($sformatf("tbl%0d.en", i),   core_enable, tv[i].e_en);
            chk($sformatf("tbl%0d.gid", i),  grant_id, tv[i].e_gid);
            chk($sformatf("tbl%0d.sout", i), state_out, exp_s);
            tick();
        end

        // ---- single request, core latency 12 ----
        do_reset();
        req_state0 = STATE_W'(1);
        req_state1 = rand_state();
        exp_s = ~req_state0;
        run_req("single", 2'b01, 12, 14, 1'b0, 2'b01, exp_s, 1'b0);

        // ---- watchdog abort: state_out keeps the previous result ----
        req_state0 = STATE_W'(5);
        run_req("wdog", 2'b01, NEVER, TIMEOUT + 1, 1'b1, 2'b01, exp_s, 1'b0);
        // Pointer flipped by the aborted run: requester 1 wins the tie.
        run_req("rr_after_abort", 2'b11, 3, 5, 1'b0, 2'b10, ~req_state1, 1'b0);

        // ---- core_done on the exact timeout cycle ----
        req_state0 = rand_state();
        run_req("tie", 2'b01, TIMEOUT - 1, TIMEOUT + 1, 1'b0, 2'b01, ~req_state0, 1'b0);

        // ---- late drop: masked cycle, then re-grant ----
        req_state0 = rand_state();
        run_req("late", 2'b01, 2, 4, 1'b0, 2'b01, ~req_state0, 1'b1);

        // ---- reset in the middle of a run ----
        do_reset();
        req_state1 = rand_state();
        run_req("pre_rst", 2'b10, 4, 6, 1'b0, 2'b10, ~req_state1, 1'b0);
        req_state1 = rand_state();
        req_valid  = 2'b10;
        for (int k = 0; k < 5; k++) tick();
        chk("midrst.busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 2'b00;
        check_reset("midrst");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("midrst.no_done%0d", k), done, 0);
        end
        req_state0 = rand_state();
        run_req("after_rst", 2'b11, 5, 7, 1'b0, 2'b01, ~req_state0, 1'b0);

        // ---- randomized run against the timeline model ----
        random_phase(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_xoodoo_core_arbiter
`default_nettype wire
